// File: rtl/dmem_copy_engine.sv
// Data-memory block copy / fill initiator. Owns the single memory port while Busy is high;
// word k of a copy is read in one cycle and written in the next.
module dmem_copy_engine #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic              Abort,
  input  logic              Fill,
  input  logic [ADDR_W-1:0] Src_Addr,
  input  logic [ADDR_W-1:0] Dst_Addr,
  input  logic [LEN_W-1:0]  Length,
  input  logic [WIDTH-1:0]  Fill_Value,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [WIDTH-1:0]  Mem_WD,
  output logic              Mem_WE,
  input  logic [WIDTH-1:0]  Mem_RD,
  output logic              Busy,
  output logic              Done,
  output logic [LEN_W-1:0]  Words_Done
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic [WIDTH-1:0]  data;
  logic [WIDTH-1:0]  fill_val;
  logic              fill_q;
  logic              last_word;

  assign last_word = (Words_Done + LEN_W'(1)) == len;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      src        <= '0;
      dst        <= '0;
      len        <= '0;
      data       <= '0;
      fill_val   <= '0;
      fill_q     <= 1'b0;
      Words_Done <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            src        <= Src_Addr;
            dst        <= Dst_Addr;
            len        <= Length;
            fill_q     <= Fill;
            fill_val   <= Fill_Value;
            Words_Done <= '0;
            if (Length == '0) state <= DONE;
            else              state <= Fill ? WRITE : READ;
          end
        end
        READ: begin
          if (Abort) begin
            state <= IDLE;
          end else begin
            data  <= Mem_RD;
            src   <= src + ADDR_W'(1);
            state <= WRITE;
          end
        end
        WRITE: begin
          // The write has already been presented this cycle, so it counts even on abort.
          dst        <= dst + ADDR_W'(1);
          Words_Done <= Words_Done + LEN_W'(1);
          if (Abort)          state <= IDLE;
          else if (last_word) state <= DONE;
          else                state <= fill_q ? WRITE : READ;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Port decode is a pure function of registered state, so reset releases the port at once.
  always_comb begin
    Mem_Address = '0;
    Mem_WD      = '0;
    Mem_WE      = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (state)
      READ: begin
        Mem_Address = src;
        Busy        = 1'b1;
      end
      WRITE: begin
        Mem_Address = dst;
        Mem_WD      = fill_q ? fill_val : data;
        Mem_WE      = 1'b1;
        Busy        = 1'b1;
      end
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Bench for dmem_copy_engine: 64-word memory with combinational read, and a reference
// model that applies each copy/fill word by word in ascending order.
module tb_dmem_copy_engine;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Start, Abort, Fill;
  logic [31:0] Src_Addr, Dst_Addr, Fill_Value;
  logic [7:0]  Length;
  logic [31:0] Mem_Address, Mem_WD, Mem_RD;
  logic        Mem_WE, Busy, Done;
  logic [7:0]  Words_Done;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  dmem_copy_engine #(.WIDTH(32), .ADDR_W(32), .LEN_W(8)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Abort(Abort), .Fill(Fill),
    .Src_Addr(Src_Addr), .Dst_Addr(Dst_Addr), .Length(Length), .Fill_Value(Fill_Value),
    .Mem_Address(Mem_Address), .Mem_WD(Mem_WD), .Mem_WE(Mem_WE), .Mem_RD(Mem_RD),
    .Busy(Busy), .Done(Done), .Words_Done(Words_Done)
  );

  assign Mem_RD = mem[Mem_Address[5:0]];
  always @(posedge CLK) if (Mem_WE) mem[Mem_Address[5:0]] <= Mem_WD;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    int errs = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) errs++;
    chk({tag, " mem"}, 64'(errs), 64'd0);
  endtask

  task automatic scramble_operands();
    Src_Addr   = $urandom;
    Dst_Addr   = $urandom;
    Length     = 8'($urandom);
    Fill       = 1'($urandom);
    Fill_Value = $urandom;
  endtask

  task automatic model(input logic f, input logic [31:0] s, input logic [31:0] d,
                       input int l, input logic [31:0] v);
    for (int k = 0; k < l; k++) begin
      logic [31:0] sa, da;
      sa = s + 32'(k);
      da = d + 32'(k);
      ref_mem[da[5:0]] = f ? v : ref_mem[sa[5:0]];
    end
  endtask

  task automatic issue(input logic f, input logic [31:0] s, input logic [31:0] d,
                       input logic [7:0] l, input logic [31:0] v);
    @(negedge CLK);
    Fill = f; Src_Addr = s; Dst_Addr = d; Length = l; Fill_Value = v; Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
    scramble_operands();
  endtask

  // Full operation with timing checks; j indexes the cycle after edge j (edge 0 samples Start).
  task automatic run_op(input string tag, input logic f, input logic [31:0] s,
                        input logic [31:0] d, input logic [7:0] l, input logic [31:0] v);
    int done_at = -1, done_cnt = 0, we_cnt = 0, busy_cnt = 0;
    int exp_lat;
    exp_lat = f ? int'(l) : 2 * int'(l);
    model(f, s, d, int'(l), v);
    issue(f, s, d, l, v);
    for (int j = 0; j < exp_lat + 4; j++) begin
      @(negedge CLK);
      if (Done) begin done_cnt++; if (done_at < 0) done_at = j; end
      if (Mem_WE) we_cnt++;
      if (Busy) busy_cnt++;
    end
    chk({tag, " done_at"}, 64'(done_at), 64'(exp_lat));
    chk({tag, " done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, " we_cnt"}, 64'(we_cnt), 64'(l));
    chk({tag, " busy_cnt"}, 64'(busy_cnt), 64'(exp_lat));
    chk({tag, " words_done"}, 64'(Words_Done), 64'(l));
    chk_mem(tag);
  endtask

  initial begin
    int done_cnt, we_cnt;
    RST = 1'b1; Start = 1'b0; Abort = 1'b0;
    Fill = 1'b0; Src_Addr = '0; Dst_Addr = '0; Length = '0; Fill_Value = '0;
    for (int i = 0; i < 64; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    repeat (3) @(posedge CLK);
    #1;
    chk("rst busy", 64'(Busy), 0);
    chk("rst done", 64'(Done), 0);
    chk("rst we", 64'(Mem_WE), 0);
    chk("rst addr", 64'(Mem_Address), 0);
    chk("rst wd", 64'(Mem_WD), 0);
    chk("rst words", 64'(Words_Done), 0);
    @(negedge CLK) RST = 1'b0;

    // directed copy
    for (int i = 0; i < 4; i++) begin mem[i] = 32'(11 * (i + 1)); ref_mem[i] = mem[i]; end
    run_op("copy4", 1'b0, 32'd0, 32'd10, 8'd4, 32'd0);
    chk("copy4 mem13", 64'(mem[13]), 64'd44);

    run_op("fill5", 1'b1, 32'd0, 32'd20, 8'd5, 32'hDEADBEEF);
    chk("fill5 mem24", 64'(mem[24]), 64'hDEADBEEF);

    run_op("len0", 1'b0, 32'd3, 32'd30, 8'd0, 32'd0);

    // overlap, dst above src: already-written data propagates
    for (int i = 0; i < 3; i++) begin mem[i] = 32'(i + 1); ref_mem[i] = mem[i]; end
    run_op("overlap", 1'b0, 32'd0, 32'd1, 8'd2, 32'd0);
    chk("overlap mem1", 64'(mem[1]), 64'd1);
    chk("overlap mem2", 64'(mem[2]), 64'd1);

    // address wrap past 2^32-1
    run_op("wrap", 1'b0, 32'hFFFF_FFFE, 32'd40, 8'd4, 32'd0);

    // abort sampled at edge 6 (end of write of word 2); stray Start while busy
    model(1'b0, 32'd0, 32'd50, 3, 32'd0);
    issue(1'b0, 32'd0, 32'd50, 8'd6, 32'd0);
    done_cnt = 0; we_cnt = 0;
    for (int j = 0; j < 14; j++) begin
      @(negedge CLK);
      if (Done) done_cnt++;
      if (Mem_WE) we_cnt++;
      Start = (j == 2);
      if (j == 2) begin Fill = 1'b1; Dst_Addr = 32'd5; Length = 8'd9; end
      Abort = (j == 5);
    end
    Start = 1'b0; Abort = 1'b0;
    chk("abort done", 64'(done_cnt), 0);
    chk("abort we", 64'(we_cnt), 3);
    chk("abort words", 64'(Words_Done), 3);
    chk("abort busy", 64'(Busy), 0);
    chk_mem("abort");

    // reset mid-read
    issue(1'b0, 32'd0, 32'd60, 8'd4, 32'd0);
    @(negedge CLK);
    chk("rstmid busy_before", 64'(Busy), 1);
    RST = 1'b1;
    #1;
    chk("rstmid busy", 64'(Busy), 0);
    chk("rstmid we", 64'(Mem_WE), 0);
    chk("rstmid addr", 64'(Mem_Address), 0);
    @(negedge CLK) RST = 1'b0;
    we_cnt = 0;
    for (int j = 0; j < 10; j++) begin @(negedge CLK); if (Mem_WE || Busy) we_cnt++; end
    chk("rstmid idle", 64'(we_cnt), 0);
    chk_mem("rstmid");
    run_op("after_rst", 1'b0, 32'd0, 32'd60, 8'd4, 32'd0);

    // randomized operations, including overlapping regions
    for (int t = 0; t < 20; t++) begin
      logic f;
      logic [31:0] s, d, v;
      logic [7:0] l;
      f = 1'($urandom); s = $urandom; d = $urandom; v = $urandom;
      l = 8'($urandom_range(0, 12));
      run_op($sformatf("rand%0d", t), f, s, d, l, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
